// File: rtl/dcc_pkg.sv
// Shared types for the DCC bus controller: arbiter state encoding and bus owner codes.
package dcc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REL,
        GRANT,
        RET
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_MSH = 2'd0,
        OWN_SSH = 2'd1,
        OWN_SCU = 2'd2
    } owner_t;

endpackage

// File: rtl/dcc_bus_arbiter.sv
// Master SH-2 external bus arbiter: runs the BRLS_N/BGR_N release handshake and hands the
// bus round-robin to the slave SH-2 or the SCU, with a guaranteed master window between tenures.
module dcc_bus_arbiter
    import dcc_pkg::*;
#(
    parameter int unsigned MASTER_GAP = 4,
    parameter int unsigned MAX_TENURE = 64
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic       RES_N,
    input  logic       BREQ_N,
    input  logic       EXBREQ_N,
    input  logic       BGR_N,
    output logic       BRLS_N,
    output logic       BACK_N,
    output logic       EXBACK_N,
    output logic [1:0] OWNER,
    output logic       TENURE_OVF
);

    localparam int unsigned TW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
    localparam int unsigned GW = (MASTER_GAP > 0) ? $clog2(MASTER_GAP + 1) : 1;
    localparam logic [TW-1:0] TEN_MAX  = TW'(MAX_TENURE);
    localparam logic [GW-1:0] GAP_INIT = GW'(MASTER_GAP);

    arb_state_t    state_q, state_d;
    owner_t        sel_q, sel_d;
    owner_t        last_q, last_d;
    owner_t        owner_q, owner_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] ten_q, ten_d;
    logic          brls_q, brls_d;
    logic          back_q, back_d;
    logic          exback_q, exback_d;
    logic          ovf_q, ovf_d;

    logic ssh_req, scu_req, sel_req, oth_req;

    assign ssh_req = ~BREQ_N;
    assign scu_req = ~EXBREQ_N;
    assign sel_req = (sel_q == OWN_SSH) ? ssh_req : scu_req;
    assign oth_req = (sel_q == OWN_SSH) ? scu_req : ssh_req;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        owner_d  = owner_q;
        gap_d    = gap_q;
        ten_d    = ten_q;
        brls_d   = brls_q;
        back_d   = back_q;
        exback_d = exback_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (ssh_req || scu_req) begin
                    // On a tie the requester that did not hold the bus last wins.
                    if (ssh_req && scu_req)
                        sel_d = (last_q == OWN_SSH) ? OWN_SCU : OWN_SSH;
                    else
                        sel_d = ssh_req ? OWN_SSH : OWN_SCU;
                    brls_d  = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (!sel_req) begin
                    brls_d  = 1'b1;
                    state_d = RET;
                end else if (!BGR_N) begin
                    if (sel_q == OWN_SSH)
                        back_d = 1'b0;
                    else
                        exback_d = 1'b0;
                    owner_d = sel_q;
                    ten_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A master abort (BGR_N high) ends the tenure exactly like a request drop.
                if (!sel_req || BGR_N) begin
                    back_d   = 1'b1;
                    exback_d = 1'b1;
                    brls_d   = 1'b1;
                    ovf_d    = 1'b0;
                    last_d   = sel_q;
                    state_d  = RET;
                end else begin
                    if (ten_q == TEN_MAX && oth_req)
                        ovf_d = 1'b1;
                    if (ten_q != TEN_MAX)
                        ten_d = ten_q + 1'b1;
                end
            end
            RET: begin
                if (BGR_N) begin
                    owner_d = OWN_MSH;
                    gap_d   = GAP_INIT;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            sel_q    <= OWN_SSH;
            last_q   <= OWN_SCU;
            owner_q  <= OWN_MSH;
            gap_q    <= '0;
            ten_q    <= '0;
            brls_q   <= 1'b1;
            back_q   <= 1'b1;
            exback_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (!RES_N) begin
            state_q  <= IDLE;
            sel_q    <= OWN_SSH;
            last_q   <= OWN_SCU;
            owner_q  <= OWN_MSH;
            gap_q    <= '0;
            ten_q    <= '0;
            brls_q   <= 1'b1;
            back_q   <= 1'b1;
            exback_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (CE_R) begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            gap_q    <= gap_d;
            ten_q    <= ten_d;
            brls_q   <= brls_d;
            back_q   <= back_d;
            exback_q <= exback_d;
            ovf_q    <= ovf_d;
        end
    end

    assign BRLS_N     = brls_q;
    assign BACK_N     = back_q;
    assign EXBACK_N   = exback_q;
    assign OWNER      = owner_q;
    assign TENURE_OVF = ovf_q;

endmodule

// File: tb/tb_dcc_bus_arbiter.sv
// Scoreboarded random/directed bench for dcc_bus_arbiter against a phase-level bus-ownership model.
module tb_dcc_bus_arbiter;

    localparam int GAP  = 4;
    localparam int MAXT = 64;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CE_R = 1'b1;
    logic       RES_N = 1'b1;
    logic       BREQ_N = 1'b1;
    logic       EXBREQ_N = 1'b1;
    logic       BGR_N = 1'b1;
    logic       BRLS_N, BACK_N, EXBACK_N, TENURE_OVF;
    logic [1:0] OWNER;

    dcc_bus_arbiter #(
        .MASTER_GAP(GAP),
        .MAX_TENURE(MAXT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE_R      (CE_R),
        .RES_N     (RES_N),
        .BREQ_N    (BREQ_N),
        .EXBREQ_N  (EXBREQ_N),
        .BGR_N     (BGR_N),
        .BRLS_N    (BRLS_N),
        .BACK_N    (BACK_N),
        .EXBACK_N  (EXBACK_N),
        .OWNER     (OWNER),
        .TENURE_OVF(TENURE_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       brls;
        logic       back;
        logic       exback;
        logic [1:0] owner;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycno = 0;

    // Model: phase 0 master owns, 1 asking master, 2 requester holds bus, 3 handing back.
    int   m_phase, m_who, m_holder, m_prev, m_gap, m_held;
    logic m_ovf;

    int follow_pct = 100;
    int abort_pm   = 0;
    int left_ssh   = 0;
    int left_scu   = 0;

    function automatic logic wants(input int who);
        return (who == 1) ? !BREQ_N : !EXBREQ_N;
    endfunction

    task automatic m_reset();
        m_phase  = 0;
        m_who    = 1;
        m_holder = 0;
        m_prev   = 2;
        m_gap    = 0;
        m_held   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic m_step();
        if (!RES_N) begin
            m_reset();
        end else if (CE_R) begin
            case (m_phase)
                0: if (m_gap > 0) m_gap--;
                   else if (!BREQ_N || !EXBREQ_N) begin
                       if (!BREQ_N && !EXBREQ_N) m_who = (m_prev == 1) ? 2 : 1;
                       else m_who = !BREQ_N ? 1 : 2;
                       m_phase = 1;
                   end
                1: if (!wants(m_who)) m_phase = 3;
                   else if (!BGR_N) begin
                       m_holder = m_who;
                       m_held   = 0;
                       m_phase  = 2;
                   end
                2: if (!wants(m_who) || BGR_N) begin
                       m_prev  = m_who;
                       m_ovf   = 1'b0;
                       m_phase = 3;
                   end else begin
                       if (m_held == MAXT && wants(3 - m_who)) m_ovf = 1'b1;
                       if (m_held < MAXT) m_held++;
                   end
                default: if (BGR_N) begin
                       m_holder = 0;
                       m_gap    = GAP;
                       m_phase  = 0;
                   end
            endcase
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.brls   = !(m_phase == 1 || m_phase == 2);
        e.back   = !(m_phase == 2 && m_who == 1);
        e.exback = !(m_phase == 2 && m_who == 2);
        e.owner  = 2'(m_holder);
        e.ovf    = m_ovf;
        e.cyc    = cycno;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int c, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, req);
        end
    endtask

    // Monitor: half a cycle's worth of outputs is checked 1ns after every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(CLK);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("brls_n",     e.cyc, {1'b0, BRLS_N},     {1'b0, e.brls});
                chk("back_n",     e.cyc, {1'b0, BACK_N},     {1'b0, e.back});
                chk("exback_n",   e.cyc, {1'b0, EXBACK_N},   {1'b0, e.exback});
                chk("owner",      e.cyc, OWNER,              e.owner);
                chk("tenure_ovf", e.cyc, {1'b0, TENURE_OVF}, {1'b0, e.ovf});
            end
        end
    end

    task automatic cyc(input logic b, input logic e, input logic ce, input logic res, input logic rst);
        @(negedge CLK);
        cycno++;
        if (BGR_N != BRLS_N && $urandom_range(99) < follow_pct)
            BGR_N = BRLS_N;
        else if (!BGR_N && abort_pm > 0 && $urandom_range(999) < abort_pm)
            BGR_N = 1'b1;
        BREQ_N   = b;
        EXBREQ_N = e;
        CE_R     = ce;
        RES_N    = res;
        RST_N    = rst;
        if (!rst) m_reset();
        push_exp();
        @(posedge CLK);
        if (rst) m_step();
        push_exp();
    endtask

    task automatic rep(input int n, input logic b, input logic e, input logic ce);
        for (int i = 0; i < n; i++) cyc(b, e, ce, 1'b1, 1'b1);
    endtask

    task automatic run_random(input int n, input int p_req, input int max_hold,
                              input int p_ce_low, input int p_res);
        logic ce, res;
        for (int i = 0; i < n; i++) begin
            if (left_ssh > 0) left_ssh--;
            else if ($urandom_range(99) < p_req) left_ssh = $urandom_range(max_hold, 1);
            if (left_scu > 0) left_scu--;
            else if ($urandom_range(99) < p_req) left_scu = $urandom_range(max_hold, 1);
            ce  = ($urandom_range(99) >= p_ce_low);
            res = ($urandom_range(999) >= p_res);
            cyc(!(left_ssh > 0), !(left_scu > 0), ce, res, 1'b1);
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge CLK);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rep(3, 1'b1, 1'b1, 1'b1);

        // Slave SH-2 alone, master answering one cycle after BRLS_N.
        rep(12, 1'b0, 1'b1, 1'b1);
        rep(10, 1'b1, 1'b1, 1'b1);

        // Simultaneous requests from reset: slave first, SCU after the master window.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rep(8, 1'b0, 1'b0, 1'b1);
        rep(20, 1'b1, 1'b0, 1'b1);
        rep(10, 1'b1, 1'b1, 1'b1);

        // Back-to-back SCU tenures.
        for (int k = 0; k < 3; k++) begin
            rep(6, 1'b1, 1'b0, 1'b1);
            rep(1, 1'b1, 1'b1, 1'b1);
        end
        rep(10, 1'b1, 1'b1, 1'b1);

        // Long SCU tenure with the slave waiting: overflow then clear on release.
        rep(3, 1'b1, 1'b0, 1'b1);
        rep(80, 1'b0, 1'b0, 1'b1);
        rep(15, 1'b0, 1'b1, 1'b1);
        rep(10, 1'b1, 1'b1, 1'b1);

        // SCU withdraws while the master has not yet granted.
        follow_pct = 0;
        rep(4, 1'b1, 1'b0, 1'b1);
        rep(3, 1'b1, 1'b1, 1'b1);
        follow_pct = 100;
        rep(10, 1'b1, 1'b1, 1'b1);

        // Async reset mid-tenure followed by a clock-enable freeze.
        rep(6, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        rep(10, 1'b0, 1'b0, 1'b0);
        rep(10, 1'b0, 1'b1, 1'b1);

        // Soft reset while CE_R is low still takes effect.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        rep(5, 1'b0, 1'b1, 1'b0);
        rep(10, 1'b1, 1'b1, 1'b1);

        follow_pct = 60;
        abort_pm   = 0;
        run_random(1500, 20, 12, 10, 0);
        run_random(1500, 40, 90, 5, 0);
        abort_pm = 20;
        run_random(1500, 30, 20, 20, 5);
        follow_pct = 100;
        abort_pm   = 0;
        rep(20, 1'b1, 1'b1, 1'b1);

        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
